// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request and registers the
// delivered PC/instruction pair for the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_pc_p1;
  logic [31:0] w_pc_p1_nxt;
  logic [31:0] r_instr_p1;
  logic [31:0] w_instr_p1_nxt;
  logic        r_vld_p1;
  logic        w_vld_p1_nxt;
  logic        r_fault;
  logic        w_fault_nxt;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;

  logic        w_req;
  logic        w_accept;
  logic        w_aligned;

  // Sequential fetch advances by one word; wraps silently at the top of memory.
  function automatic logic [31:0] f_next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  always_comb begin
    w_aligned = (redirect_PC[1:0] == 2'b00);
    // Reset gates the request so a same-cycle imem_ready can never be accepted.
    w_req     = (r_state == FETCH) && !stall && !redirect && !reset;
    w_accept  = w_req && imem_ready;

    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pc_p1_nxt    = r_pc_p1;
    w_instr_p1_nxt = r_instr_p1;
    w_vld_p1_nxt   = r_vld_p1;
    w_fault_nxt    = r_fault;
    w_count_nxt    = r_count;

    case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
      end
      FETCH, FAULT: begin
        if (redirect) begin
          w_pc_nxt       = redirect_PC;
          w_pc_p1_nxt    = 32'd0;
          w_instr_p1_nxt = 32'd0;
          w_vld_p1_nxt   = 1'b0;
          if (w_aligned) begin
            w_state_nxt = FETCH;
            w_fault_nxt = 1'b0;
          end else begin
            w_state_nxt = FAULT;
            w_fault_nxt = 1'b1;
          end
        end else if (w_accept) begin
          w_pc_nxt       = f_next_pc(r_pc);
          w_pc_p1_nxt    = r_pc;
          w_instr_p1_nxt = imem_rdata;
          w_vld_p1_nxt   = 1'b1;
          w_count_nxt    = r_count + 32'd1;
        end else if (w_req) begin
          // Memory not ready: present a bubble but keep the last delivered PC.
          w_instr_p1_nxt = 32'd0;
          w_vld_p1_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // Stage p1: registered IF/ID-facing outputs and fetch control state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pc_p1    <= 32'd0;
      r_instr_p1 <= 32'd0;
      r_vld_p1   <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_p1    <= w_pc_p1_nxt;
      r_instr_p1 <= w_instr_p1_nxt;
      r_vld_p1   <= w_vld_p1_nxt;
      r_fault    <= w_fault_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign PC          = r_pc_p1;
  assign instruction = r_instr_p1;
  assign valid       = r_vld_p1;
  assign fetch_fault = r_fault;
  assign fetch_count = r_count;

endmodule
